// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding, state width,
// and a small elaboration-time helper used to size counters.
// Latency: n/a (constants only). Backpressure: n/a.
package rst_seq_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_HOLD      = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_RELEASE   = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Purpose: STAGES-deep flop chain bringing an asynchronous level into clk.
// Latency: STAGES clk edges from d to q. Backpressure: none (free-running).
// Ports: clk, reset (sync, active-high, clears chain to 0), d (async in), q (sync out).
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/rst_seq_gen.sv
// Purpose: lock-aware reset sequencer; stretches reset, waits for PLL lock, then
//          releases N_OUT domains in index order GAP cycles apart.
// Latency: rst_out/all_done registered, 1 edge after the deciding condition; lock path adds SYNC_STAGES.
// Backpressure: none; soft_rst held high parks the FSM in S_HOLD.
// Ports: clk, reset (sync active-high), locked (async PLL lock), soft_rst (restart request),
//        rst_out[N_OUT] (active-high domain resets), all_done (high in S_RUN), state_o (FSM state).
// Build option: RST_SEQ_LOCK_MON_EN -- when defined, losing lock in S_RUN restarts the sequence.
module rst_seq_gen
    import rst_seq_pkg::*;
#(
    parameter int N_OUT       = 3,
    parameter int SYNC_STAGES = 2,
    parameter int STRETCH     = 16,
    parameter int GAP         = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               locked,
    input  logic               soft_rst,
    output logic [N_OUT-1:0]   rst_out,
    output logic               all_done,
    output logic [STATE_W-1:0] state_o
);

    localparam int CW = $clog2(max_int(STRETCH, GAP) + 1);
    localparam int IW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    localparam logic [CW-1:0]    STRETCH_LAST = CW'(STRETCH - 1);
    localparam logic [CW-1:0]    GAP_LAST     = CW'(GAP - 1);
    localparam logic [IW-1:0]    IDX_LAST     = IW'(N_OUT - 1);
    localparam logic [N_OUT-1:0] ONE_HOT0     = N_OUT'(1);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [IW-1:0]    idx, idx_nxt;
    logic [N_OUT-1:0] rst_q, rst_nxt;
    logic             lock_s;
    logic             lock_lost;

    sync_bit #(
        .STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d     (locked),
        .q     (lock_s)
    );

    // Lock loss always aborts a release in progress; once running, it only
    // matters when lock monitoring is built in.
`ifdef RST_SEQ_LOCK_MON_EN
    assign lock_lost = !lock_s && ((state == S_RELEASE) || (state == S_RUN));
`else
    assign lock_lost = !lock_s && (state == S_RELEASE);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_HOLD;
            cnt   <= '0;
            idx   <= '0;
            rst_q <= '1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            rst_q <= rst_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        rst_nxt   = rst_q;

        if (soft_rst || lock_lost) begin
            // Restart: every domain reasserts on the same edge.
            state_nxt = S_HOLD;
            cnt_nxt   = '0;
            idx_nxt   = '0;
            rst_nxt   = '1;
        end else begin
            case (state)
                S_HOLD: begin
                    rst_nxt = '1;
                    if (cnt == STRETCH_LAST) begin
                        state_nxt = S_WAIT_LOCK;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    rst_nxt = '1;
                    if (lock_s) begin
                        // First domain is released on the transition edge itself.
                        state_nxt = S_RELEASE;
                        rst_nxt   = ~ONE_HOT0;
                        idx_nxt   = '0;
                        cnt_nxt   = '0;
                    end
                end
                S_RELEASE: begin
                    if (idx == IDX_LAST) begin
                        // Last domain already released: one more edge, then run.
                        state_nxt = S_RUN;
                        cnt_nxt   = '0;
                    end else if (cnt == GAP_LAST) begin
                        idx_nxt = idx + 1'b1;
                        rst_nxt = rst_q & ~(ONE_HOT0 << idx_nxt);
                        cnt_nxt = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    rst_nxt = '0;
                end
                default: begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    rst_nxt   = '1;
                end
            endcase
        end
    end

    assign rst_out  = rst_q;
    assign all_done = (state == S_RUN);
    assign state_o  = state;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Bench for rst_seq_gen: default-parameter DUT checked every cycle against a
// timeline model, plus a N_OUT=1/GAP=1 instance pinned with literal expectations.
module tb_rst_seq_gen;

    localparam int N    = 3;
    localparam int SS   = 2;
    localparam int ST   = 16;
    localparam int G    = 8;
    localparam int LAST = (N - 1) * G;   // release offset of the last domain
`ifdef RST_SEQ_LOCK_MON_EN
    localparam bit MON = 1'b1;
`else
    localparam bit MON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         locked;
    logic         soft_rst;
    logic [N-1:0] rst_out;
    logic         all_done;
    logic [1:0]   state_o;
    logic [0:0]   rst_out1;
    logic         all_done1;
    logic [1:0]   state_o1;

    always #5 clk = ~clk;

    rst_seq_gen #(.N_OUT(N), .SYNC_STAGES(SS), .STRETCH(ST), .GAP(G)) dut (
        .clk(clk), .reset(reset), .locked(locked), .soft_rst(soft_rst),
        .rst_out(rst_out), .all_done(all_done), .state_o(state_o)
    );

    rst_seq_gen #(.N_OUT(1), .SYNC_STAGES(SS), .STRETCH(ST), .GAP(1)) dut1 (
        .clk(clk), .reset(reset), .locked(locked), .soft_rst(soft_rst),
        .rst_out(rst_out1), .all_done(all_done1), .state_o(state_o1)
    );

    // Edges counted since reset was last sampled high.
    int edge_n = 0;
    always @(posedge clk) begin
        if (reset) edge_n <= 0;
        else       edge_n <= edge_n + 1;
    end

    // Timeline model: m_t = edges spent since the sequence (re)started,
    // m_rel = edges since domain 0 was released (-1 = not released yet),
    // lock_hist = locked as seen over the last SS edges (lock_s is the oldest).
    int m_t   = 0;
    int m_rel = -1;
    bit lock_hist [SS];

    always @(posedge clk) begin
        bit ls;
        ls = lock_hist[SS-1];
        if (reset || soft_rst) begin
            m_t   = 0;
            m_rel = -1;
        end else if (m_rel >= 0) begin
            if (!ls && (m_rel <= LAST || MON)) begin
                m_t   = 0;
                m_rel = -1;
            end else if (m_rel < 100000) begin
                m_rel = m_rel + 1;
            end
        end else if (m_t >= ST && ls) begin
            m_rel = 0;
        end else if (m_t < 100000) begin
            m_t = m_t + 1;
        end
        if (reset) begin
            for (int i = 0; i < SS; i++) lock_hist[i] = 1'b0;
        end else begin
            for (int i = SS - 1; i > 0; i--) lock_hist[i] = lock_hist[i-1];
            lock_hist[0] = locked;
        end
    end

    function automatic logic [N-1:0] exp_rst();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = !(m_rel >= i * G);
        return v;
    endfunction

    function automatic logic [1:0] exp_state();
        if (m_rel < 0) return (m_t >= ST) ? 2'd1 : 2'd0;
        return (m_rel > LAST) ? 2'd3 : 2'd2;
    endfunction

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_n, act, exp);
        end
    endtask

    // Advance one cycle and compare against the model at the falling edge.
    task automatic step();
        @(negedge clk);
        if (started) begin
            chk("model_rst_out",  32'(rst_out),  32'(exp_rst()));
            chk("model_state",    32'(state_o),  32'(exp_state()));
            chk("model_all_done", 32'(all_done), 32'(m_rel > LAST));
        end
    endtask

    task automatic goto(input int k);
        int guard;
        guard = 0;
        while (edge_n < k && guard < 2000) begin
            step();
            guard++;
        end
        chk("goto_edge", 32'(edge_n), 32'(k));
    endtask

    task automatic lit(input string name, input logic [N-1:0] r, input logic [1:0] s, input logic d);
        chk({name, "_rst"},   32'(rst_out),  32'(r));
        chk({name, "_state"}, 32'(state_o),  32'(s));
        chk({name, "_done"},  32'(all_done), 32'(d));
    endtask

    initial begin
        reset    = 1'b1;
        soft_rst = 1'b0;
        locked   = 1'b1;
        step();
        step();
        started = 1'b1;
        lit("reset_vals", 3'b111, 2'd0, 1'b0);
        chk("n1_reset_rst", 32'(rst_out1), 32'd1);
        reset = 1'b0;

        // Normal power-up with lock already present.
        goto(16); lit("e16_wait", 3'b111, 2'd1, 1'b0);
        chk("n1_e16_state", 32'(state_o1), 32'd1);
        goto(17); lit("e17_rel0", 3'b110, 2'd2, 1'b0);
        chk("n1_e17_rst", 32'(rst_out1), 32'd0);
        chk("n1_e17_state", 32'(state_o1), 32'd2);
        chk("n1_e17_done", 32'(all_done1), 32'd0);
        goto(18);
        chk("n1_e18_done", 32'(all_done1), 32'd1);
        chk("n1_e18_state", 32'(state_o1), 32'd3);
        goto(24); lit("e24", 3'b110, 2'd2, 1'b0);
        goto(25); lit("e25_rel1", 3'b100, 2'd2, 1'b0);
        goto(33); lit("e33_rel2", 3'b000, 2'd2, 1'b0);
        goto(34); lit("e34_run", 3'b000, 2'd3, 1'b1);

        // Soft reset pulse while running.
        goto(40); soft_rst = 1'b1;
        goto(41); lit("soft_hold", 3'b111, 2'd0, 1'b0);
        soft_rst = 1'b0;
        goto(57); lit("soft_e57", 3'b111, 2'd1, 1'b0);
        goto(58); lit("soft_rel0", 3'b110, 2'd2, 1'b0);
        goto(80); lit("soft_run", 3'b000, 2'd3, 1'b1);

        // Reset together with soft_rst while running.
        reset = 1'b1; soft_rst = 1'b1;
        step();
        lit("rst_soft", 3'b111, 2'd0, 1'b0);
        reset = 1'b0; soft_rst = 1'b0;

        // Lock drops during release.
        goto(28); lit("lr_e28", 3'b100, 2'd2, 1'b0);
        locked = 1'b0;
        goto(30); lit("lr_e30", 3'b100, 2'd2, 1'b0);
        goto(31); lit("lr_abort", 3'b111, 2'd0, 1'b0);
        goto(35); locked = 1'b1;
        goto(47); lit("lr_wait", 3'b111, 2'd1, 1'b0);
        goto(48); lit("lr_rel0", 3'b110, 2'd2, 1'b0);

        // Late lock after reset.
        reset = 1'b1; locked = 1'b0;
        step();
        reset = 1'b0;
        goto(40); lit("late_e40", 3'b111, 2'd1, 1'b0);
        locked = 1'b1;
        goto(42); lit("late_e42", 3'b111, 2'd1, 1'b0);
        goto(43); lit("late_rel0", 3'b110, 2'd2, 1'b0);

        // Lock drops while running.
        goto(65); lit("run_e65", 3'b000, 2'd3, 1'b1);
        locked = 1'b0;
        goto(67); lit("run_e67", 3'b000, 2'd3, 1'b1);
        goto(68);
        lit("run_e68", MON ? 3'b111 : 3'b000, MON ? 2'd0 : 2'd3, !MON);
        goto(72);
        lit("run_e72", MON ? 3'b111 : 3'b000, MON ? 2'd0 : 2'd3, !MON);
        locked = 1'b1;

        // soft_rst held high parks the FSM in S_HOLD with the counter at 0.
        soft_rst = 1'b1;
        goto(100); lit("softh_e100", 3'b111, 2'd0, 1'b0);
        soft_rst = 1'b0;
        goto(115); lit("softh_e115", 3'b111, 2'd0, 1'b0);
        goto(116); lit("softh_wait", 3'b111, 2'd1, 1'b0);
        goto(117); lit("softh_rel0", 3'b110, 2'd2, 1'b0);
        goto(135); lit("softh_run", 3'b000, 2'd3, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
